// File: rtl/scr1_dmem_router.sv
// scr1_dmem_router: routes core LSU data requests to the TCM or the external
// data bridge by address decode, and tracks the single outstanding transaction.
// Optional feature macro: SCR1_TCM_EN. When it is undefined, every access goes
// to the external bridge and all tcm_* outputs are held at zero.
//
// state     | meaning
// ----------+------------------------------------------------------------
// FSM_IDLE  | nothing outstanding; requests forwarded to the decoded port
// FSM_WAIT  | one transaction outstanding on port r_sel; forward only on completion

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_router_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_router
    import scr1_dmem_router_pkg::*;
#(
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ADDR_MASK    = 32'hFFFF0000,
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ADDR_PATTERN = 32'h00480000
)(
    input  logic                           clk,
    input  logic                           rst_n,
    // core side
    input  logic                           dmem_req,
    input  type_scr1_mem_cmd_e             dmem_cmd,
    input  type_scr1_mem_width_e           dmem_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
    output logic                           dmem_req_ack,
    output logic [`SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
    output type_scr1_mem_resp_e            dmem_resp,
    // TCM port
    output logic                           tcm_req,
    output type_scr1_mem_cmd_e             tcm_cmd,
    output type_scr1_mem_width_e           tcm_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]   tcm_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0]   tcm_wdata,
    input  logic                           tcm_req_ack,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]   tcm_rdata,
    input  type_scr1_mem_resp_e            tcm_resp,
    // external bridge port
    output logic                           ext_req,
    output type_scr1_mem_cmd_e             ext_cmd,
    output type_scr1_mem_width_e           ext_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]   ext_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0]   ext_wdata,
    input  logic                           ext_req_ack,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]   ext_rdata,
    input  type_scr1_mem_resp_e            ext_resp
);

    typedef enum logic { FSM_IDLE = 1'b0, FSM_WAIT = 1'b1 } fsm_e;
    typedef enum logic { SEL_TCM  = 1'b0, SEL_EXT  = 1'b1 } sel_e;

    fsm_e                           r_fsm;
    sel_e                           w_port_sel;
    logic                           w_hit_tcm;
    logic                           w_sel_ack;
    logic                           w_complete;
    logic                           w_fwd_en;
    logic                           w_accept;
    type_scr1_mem_resp_e            w_own_resp;
    logic [`SCR1_DMEM_DWIDTH-1:0]   w_own_rdata;

`ifdef SCR1_TCM_EN
    sel_e                           r_sel;

    assign w_hit_tcm   = ((dmem_addr & SCR1_TCM_ADDR_MASK) == SCR1_TCM_ADDR_PATTERN);
    assign w_sel_ack   = (w_port_sel == SEL_TCM) ? tcm_req_ack : ext_req_ack;
    assign w_own_resp  = (r_sel == SEL_TCM) ? tcm_resp  : ext_resp;
    assign w_own_rdata = (r_sel == SEL_TCM) ? tcm_rdata : ext_rdata;

    assign tcm_req     = w_fwd_en & dmem_req & (w_port_sel == SEL_TCM);
    assign tcm_cmd     = dmem_cmd;
    assign tcm_width   = dmem_width;
    assign tcm_addr    = dmem_addr;
    assign tcm_wdata   = dmem_wdata;
`else
    // TCM inputs and decode parameters have no effect in this build
    logic                           w_unused_tcm;

    assign w_unused_tcm = ^{tcm_req_ack, tcm_rdata, tcm_resp,
                            SCR1_TCM_ADDR_MASK, SCR1_TCM_ADDR_PATTERN};

    assign w_hit_tcm   = 1'b0;
    assign w_sel_ack   = ext_req_ack;
    assign w_own_resp  = ext_resp;
    assign w_own_rdata = ext_rdata;

    assign tcm_req     = 1'b0;
    assign tcm_cmd     = SCR1_MEM_CMD_RD;
    assign tcm_width   = SCR1_MEM_WIDTH_BYTE;
    assign tcm_addr    = '0;
    assign tcm_wdata   = '0;
`endif

    assign w_port_sel = w_hit_tcm ? SEL_TCM : SEL_EXT;

    // Forwarding is open in IDLE, or in WAIT on the cycle the owner completes
    // (this is what lets TCM accesses run back-to-back at one per cycle).
    assign w_complete = (r_fsm == FSM_WAIT) && (w_own_resp != SCR1_MEM_RESP_NOTRDY);
    assign w_fwd_en   = (r_fsm == FSM_IDLE) || w_complete;
    assign w_accept   = w_fwd_en & dmem_req & w_sel_ack;

    assign ext_req    = w_fwd_en & dmem_req & (w_port_sel == SEL_EXT);
    assign ext_cmd    = dmem_cmd;
    assign ext_width  = dmem_width;
    assign ext_addr   = dmem_addr;
    assign ext_wdata  = dmem_wdata;

    assign dmem_req_ack = w_fwd_en & w_sel_ack;
    assign dmem_resp    = (r_fsm == FSM_WAIT) ? w_own_resp  : SCR1_MEM_RESP_NOTRDY;
    assign dmem_rdata   = (r_fsm == FSM_WAIT) ? w_own_rdata : '0;

    // Transaction tracker: owner port is latched only when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= FSM_IDLE;
`ifdef SCR1_TCM_EN
            r_sel <= SEL_EXT;
`endif
        end else if (w_accept) begin
            r_fsm <= FSM_WAIT;
`ifdef SCR1_TCM_EN
            r_sel <= w_port_sel;
`endif
        end else if (w_complete) begin
            r_fsm <= FSM_IDLE;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Testbench for scr1_dmem_router: directed vector table applied one per cycle
// (state carries from vector to vector), plus hand-written reset sequences.
// Expectations follow the build: with SCR1_TCM_EN the TCM decode is exercised,
// otherwise every address must route to the external bridge.
`timescale 1ns/1ps

module tb_scr1_dmem_router;
    import scr1_dmem_router_pkg::*;

`ifdef SCR1_TCM_EN
    localparam bit TCM_ON = 1'b1;
`else
    localparam bit TCM_ON = 1'b0;
`endif

    localparam type_scr1_mem_resp_e N  = SCR1_MEM_RESP_NOTRDY;
    localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e ER = SCR1_MEM_RESP_RDY_ER;
    localparam type_scr1_mem_cmd_e  RD = SCR1_MEM_CMD_RD;
    localparam type_scr1_mem_cmd_e  WR = SCR1_MEM_CMD_WR;

    logic                 clk;
    logic                 rst_n;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 tcm_req;
    type_scr1_mem_cmd_e   tcm_cmd;
    type_scr1_mem_width_e tcm_width;
    logic [31:0]          tcm_addr;
    logic [31:0]          tcm_wdata;
    logic                 tcm_req_ack;
    logic [31:0]          tcm_rdata;
    type_scr1_mem_resp_e  tcm_resp;
    logic                 ext_req;
    type_scr1_mem_cmd_e   ext_cmd;
    type_scr1_mem_width_e ext_width;
    logic [31:0]          ext_addr;
    logic [31:0]          ext_wdata;
    logic                 ext_req_ack;
    logic [31:0]          ext_rdata;
    type_scr1_mem_resp_e  ext_resp;

    int n_chk  = 0;
    int n_pass = 0;

    scr1_dmem_router dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .tcm_req      (tcm_req),
        .tcm_cmd      (tcm_cmd),
        .tcm_width    (tcm_width),
        .tcm_addr     (tcm_addr),
        .tcm_wdata    (tcm_wdata),
        .tcm_req_ack  (tcm_req_ack),
        .tcm_rdata    (tcm_rdata),
        .tcm_resp     (tcm_resp),
        .ext_req      (ext_req),
        .ext_cmd      (ext_cmd),
        .ext_width    (ext_width),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_req_ack  (ext_req_ack),
        .ext_rdata    (ext_rdata),
        .ext_resp     (ext_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string               nm;
        logic                req;
        type_scr1_mem_cmd_e  cmd;
        logic [31:0]         addr;
        logic                tack;
        type_scr1_mem_resp_e tresp;
        logic [31:0]         trd;
        logic                eack;
        type_scr1_mem_resp_e eresp;
        logic [31:0]         erd;
        logic                x_ack;
        type_scr1_mem_resp_e x_resp;
        logic [31:0]         x_rd;
        logic                x_treq;
        logic                x_ereq;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic req, input type_scr1_mem_cmd_e cmd,
                       input logic [31:0] addr,
                       input logic tack, input type_scr1_mem_resp_e tresp, input logic [31:0] trd,
                       input logic eack, input type_scr1_mem_resp_e eresp, input logic [31:0] erd,
                       input logic x_ack, input type_scr1_mem_resp_e x_resp, input logic [31:0] x_rd,
                       input logic x_treq, input logic x_ereq);
        vec_t v;
        v.nm = nm; v.req = req; v.cmd = cmd; v.addr = addr;
        v.tack = tack; v.tresp = tresp; v.trd = trd;
        v.eack = eack; v.eresp = eresp; v.erd = erd;
        v.x_ack = x_ack; v.x_resp = x_resp; v.x_rd = x_rd;
        v.x_treq = x_treq; v.x_ereq = x_ereq;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic apply(input vec_t v);
        dmem_req    = v.req;
        dmem_cmd    = v.cmd;
        dmem_width  = SCR1_MEM_WIDTH_WORD;
        dmem_addr   = v.addr;
        dmem_wdata  = v.addr ^ 32'hA5A5_A5A5;
        tcm_req_ack = v.tack;
        tcm_resp    = v.tresp;
        tcm_rdata   = v.trd;
        ext_req_ack = v.eack;
        ext_resp    = v.eresp;
        ext_rdata   = v.erd;
    endtask

    task automatic check_vec(input vec_t v);
        logic [31:0] exp_wdata;
        exp_wdata = v.addr ^ 32'hA5A5_A5A5;
        chk({v.nm, ".ack"},      32'(dmem_req_ack), 32'(v.x_ack));
        chk({v.nm, ".resp"},     32'(dmem_resp),    32'(v.x_resp));
        chk({v.nm, ".rdata"},    dmem_rdata,        v.x_rd);
        chk({v.nm, ".tcm_req"},  32'(tcm_req),      32'(v.x_treq));
        chk({v.nm, ".ext_req"},  32'(ext_req),      32'(v.x_ereq));
        chk({v.nm, ".ext_addr"}, ext_addr,          v.addr);
        chk({v.nm, ".ext_wdata"},ext_wdata,         exp_wdata);
        chk({v.nm, ".ext_cmd"},  32'(ext_cmd),      32'(v.cmd));
        chk({v.nm, ".tcm_addr"}, tcm_addr,          TCM_ON ? v.addr : 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        dmem_req    = 1'b0;
        dmem_cmd    = RD;
        dmem_width  = SCR1_MEM_WIDTH_WORD;
        dmem_addr   = 32'h0;
        dmem_wdata  = 32'h0;
        tcm_req_ack = 1'b0;
        tcm_rdata   = 32'h0;
        tcm_resp    = N;
        ext_req_ack = 1'b0;
        ext_rdata   = 32'h0;
        ext_resp    = N;

        // ------------- vector table (name, req, cmd, addr, tcm ack/resp/rdata,
        //               ext ack/resp/rdata | exp ack, resp, rdata, tcm_req, ext_req)
`ifdef SCR1_TCM_EN
        add("tcm_rd_c0",  1, RD, 32'h0048_0010, 1, N,  32'h0,         0, N,  32'h0,         1, N,  32'h0,         1, 0);
        add("tcm_rd_c1",  0, RD, 32'h0000_0000, 1, OK, 32'hDEAD_BEEF, 0, N,  32'h0,         0, OK, 32'hDEAD_BEEF, 0, 0);
        add("ext_wr_w0",  1, WR, 32'h0001_0000, 1, N,  32'h0,         0, N,  32'h0,         0, N,  32'h0,         0, 1);
        add("ext_wr_w1",  1, WR, 32'h0001_0000, 1, N,  32'h0,         0, N,  32'h0,         0, N,  32'h0,         0, 1);
        add("ext_wr_acc", 1, WR, 32'h0001_0000, 1, N,  32'h0,         1, N,  32'h0,         1, N,  32'h0,         0, 1);
        add("ext_wr_p1",  0, RD, 32'h0000_0000, 1, OK, 32'h1111_1111, 0, N,  32'h0,         0, N,  32'h0,         0, 0);
        add("ext_wr_p2",  1, RD, 32'h0048_0000, 1, N,  32'h0,         1, N,  32'h0,         0, N,  32'h0,         0, 0);
        add("ext_wr_done",0, RD, 32'h0000_0000, 1, N,  32'h0,         0, OK, 32'h0000_BEEF, 0, OK, 32'h0000_BEEF, 0, 0);
        add("b2b_tcm",    1, RD, 32'h0048_0000, 1, N,  32'h0,         0, N,  32'h0,         1, N,  32'h0,         1, 0);
        add("b2b_ext",    1, RD, 32'h0002_0000, 1, OK, 32'hCAFE_F00D, 1, N,  32'h0,         1, OK, 32'hCAFE_F00D, 0, 1);
        add("b2b_spur",   0, RD, 32'h0000_0000, 1, OK, 32'hBAD0_BAD0, 0, N,  32'h0,         0, N,  32'h0,         0, 0);
        add("b2b_done",   0, RD, 32'h0000_0000, 1, N,  32'h0,         0, OK, 32'h0000_5A5A, 0, OK, 32'h0000_5A5A, 0, 0);
        add("er_req",     1, RD, 32'h0003_0000, 1, N,  32'h0,         1, N,  32'h0,         1, N,  32'h0,         0, 1);
        add("er_resp",    0, RD, 32'h0000_0000, 1, N,  32'h0,         0, ER, 32'hFFFF_FFFF, 0, ER, 32'hFFFF_FFFF, 0, 0);
        add("er_next",    1, RD, 32'h0048_0004, 1, N,  32'h0,         0, ER, 32'hFFFF_FFFF, 1, N,  32'h0,         1, 0);
        add("tcm_b2b",    1, RD, 32'h0048_0008, 1, OK, 32'h0000_0001, 0, N,  32'h0,         1, OK, 32'h0000_0001, 1, 0);
        add("tcm_last",   0, RD, 32'h0000_0000, 1, OK, 32'h0000_0002, 0, N,  32'h0,         0, OK, 32'h0000_0002, 0, 0);
        add("idle_ack",   0, RD, 32'h0048_0000, 1, OK, 32'h0000_0003, 0, N,  32'h0,         1, N,  32'h0,         0, 0);
`else
        add("tcmaddr_ext",1, RD, 32'h0048_0000, 1, N,  32'h0,         1, N,  32'h0,         1, N,  32'h0,         0, 1);
        add("tcm_ignored",0, RD, 32'h0000_0000, 1, OK, 32'h1111_1111, 0, N,  32'h0,         0, N,  32'h0,         0, 0);
        add("ext_rd_done",0, RD, 32'h0000_0000, 1, N,  32'h0,         0, OK, 32'hDEAD_BEEF, 0, OK, 32'hDEAD_BEEF, 0, 0);
        add("ext_wr_w0",  1, WR, 32'h0001_0000, 1, N,  32'h0,         0, N,  32'h0,         0, N,  32'h0,         0, 1);
        add("ext_wr_acc", 1, WR, 32'h0001_0000, 1, N,  32'h0,         1, N,  32'h0,         1, N,  32'h0,         0, 1);
        add("ext_wr_er",  0, RD, 32'h0000_0000, 1, N,  32'h0,         0, ER, 32'h0,         0, ER, 32'h0,         0, 0);
        add("tack_ignore",0, RD, 32'h0048_0000, 1, N,  32'h0,         0, N,  32'h0,         0, N,  32'h0,         0, 0);
        add("b2b_first",  1, RD, 32'h0002_0000, 1, N,  32'h0,         1, N,  32'h0,         1, N,  32'h0,         0, 1);
        add("b2b_second", 1, RD, 32'h0048_0010, 1, N,  32'h0,         1, OK, 32'h0000_0007, 1, OK, 32'h0000_0007, 0, 1);
        add("b2b_done",   0, RD, 32'h0000_0000, 1, N,  32'h0,         0, OK, 32'h0000_0008, 0, OK, 32'h0000_0008, 0, 0);
        add("idle_quiet", 0, RD, 32'h0000_0000, 1, N,  32'h0,         0, OK, 32'h0000_0009, 0, N,  32'h0,         0, 0);
`endif

        // ------------- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.resp",    32'(dmem_resp), 32'(N));
        chk("rst.rdata",   dmem_rdata,     32'h0);
        chk("rst.ack_lo",  32'(dmem_req_ack), 32'h0);
        chk("rst.tcm_req", 32'(tcm_req),   32'h0);
        chk("rst.ext_req", 32'(ext_req),   32'h0);
        ext_req_ack = 1'b1;
        #1;
        chk("rst.ack_follow", 32'(dmem_req_ack), 32'h1);
        ext_req_ack = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ------------- table
        foreach (vq[i]) begin
            @(posedge clk);
            #1 apply(vq[i]);
            #4 check_vec(vq[i]);
        end

        // ------------- reset dropped with an external read outstanding
        @(posedge clk);
        #1;
        dmem_req = 1'b1; dmem_cmd = RD; dmem_addr = 32'h0003_0000;
        tcm_req_ack = 1'b0; tcm_resp = N; ext_req_ack = 1'b1; ext_resp = N; ext_rdata = 32'h0;
        #4;
        chk("mrst.acc_ack", 32'(dmem_req_ack), 32'h1);
        chk("mrst.acc_ext", 32'(ext_req),      32'h1);
        @(posedge clk);
        #1 dmem_req = 1'b0;
        #4;
        chk("mrst.wait_ack",  32'(dmem_req_ack), 32'h0);
        chk("mrst.wait_resp", 32'(dmem_resp),    32'(N));
        #1 rst_n = 1'b0;
        #1;
        chk("mrst.in_rst_ack",  32'(dmem_req_ack), 32'h1);
        chk("mrst.in_rst_resp", 32'(dmem_resp),    32'(N));
        @(posedge clk);
        #1 rst_n = 1'b1; ext_req_ack = 1'b0;
        @(posedge clk);
        #1 ext_resp = OK; ext_rdata = 32'hAAAA_5555;
        #4;
        chk("mrst.late_resp",  32'(dmem_resp), 32'(N));
        chk("mrst.late_rdata", dmem_rdata,     32'h0);
        @(posedge clk);
        #1 ext_resp = N; dmem_req = 1'b1; ext_req_ack = 1'b1;
        #4;
        chk("mrst.idle_ack", 32'(dmem_req_ack), 32'h1);
        @(posedge clk);
        #1 dmem_req = 1'b0; ext_req_ack = 1'b0; ext_resp = OK; ext_rdata = 32'h0000_1234;
        #4;
        chk("mrst.new_resp",  32'(dmem_resp), 32'(OK));
        chk("mrst.new_rdata", dmem_rdata,     32'h0000_1234);
        @(posedge clk);
        #1 ext_resp = N;
        #4;
        chk("mrst.back_idle", 32'(dmem_resp), 32'(N));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_router.md
# scr1_dmem_router

Data-memory request router between the core LSU data interface and two target ports: the tightly-coupled memory (port TCM) and the external data bridge (port EXT). It decodes each request address against a mask/pattern pair, forwards the request to exactly one port, and tracks the single outstanding transaction. The owning port's response and read data are returned to the core. It sits directly upstream of the TCM data port.

## Interface
- SCR1_TCM_ADDR_MASK, default 32'hFFFF0000: address bits compared for TCM decode.
- SCR1_TCM_ADDR_PATTERN, default 32'h00480000: TCM hit when (dmem_addr & MASK) == PATTERN.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dmem_req  in  1  core request valid.
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR.
- dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD.
- dmem_addr  in  `SCR1_DMEM_AWIDTH  byte address.
- dmem_wdata  in  `SCR1_DMEM_DWIDTH  write data.
- dmem_req_ack  out  1  request accepted this cycle.
- dmem_rdata  out  `SCR1_DMEM_DWIDTH  read data, valid with RDY_OK on a read.
- dmem_resp  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER.
- tcm_req, tcm_cmd, tcm_width, tcm_addr, tcm_wdata  out  as core side  request to TCM.
- tcm_req_ack, tcm_rdata, tcm_resp  in  as core side  TCM handshake/response.
- ext_req, ext_cmd, ext_width, ext_addr, ext_wdata  out  as core side  request to external bridge.
- ext_req_ack, ext_rdata, ext_resp  in  as core side  external handshake/response.

## Operation
- State: fsm ∈ {IDLE, WAIT}; sel_r ∈ {TCM, EXT}. Reset: fsm=IDLE, sel_r=EXT.
- Decode: hit_tcm = ((dmem_addr & MASK) == PATTERN); port_sel = hit_tcm ? TCM : EXT.
- cmd/width/addr/wdata are driven to both ports unconditionally. Only the selected port's req is asserted.
- IDLE:
  - {port}_req = dmem_req & (port_sel == port).
  - dmem_req_ack = the selected port's req_ack.
  - dmem_resp = NOTRDY; dmem_rdata = 0.
  - On dmem_req & ack: sel_r <= port_sel and fsm -> WAIT.
- WAIT:
  - dmem_resp = resp of port sel_r; dmem_rdata = rdata of port sel_r.
  - While that resp is NOTRDY: no request is forwarded (both port reqs 0) and dmem_req_ack = 0.
  - When that resp is RDY_OK or RDY_ER (completion), the IDLE forwarding logic applies in the same cycle:
    - If dmem_req & ack: sel_r <= port_sel, stay WAIT (back-to-back).
    - Otherwise fsm -> IDLE.
- RDY_ER is passed through unchanged and counts as completion.
- A response from the non-owning port, or any response in IDLE, is ignored.
- At most one outstanding transaction, always.

## Timing
- Request path is combinational: zero added latency from dmem_req to tcm_req/ext_req.
- Response path is combinational in WAIT: zero added latency from port resp to dmem_resp.
- TCM (always acks, registered resp) gives completion 1 cycle after acceptance, so back-to-back TCM accesses sustain 1 transaction/cycle.
- Address decode uses the current-cycle dmem_addr only. sel_r is updated only on an accepted request.
- Reset asserted mid-transaction: fsm -> IDLE immediately (asynchronous), pending response discarded. Outputs return to IDLE values: dmem_resp=NOTRDY, dmem_rdata=0, dmem_req_ack follows the selected port's ack.
- No combinational path from port resp to port req except through completion in WAIT. Targets must not make req_ack depend on their own req and resp in the same cycle.

## Configuration
- SCR1_TCM_EN defined: behaviour as above.
- SCR1_TCM_EN undefined:
  - Decode is forced to EXT and the parameters are unused.
  - tcm_req=0 and the other tcm_* outputs are 0; tcm_* inputs are ignored.
  - sel_r is constant EXT.

## Test plan
- Word read to addr 32'h00480010, TCM returns RDY_OK with rdata 32'hDEADBEEF next cycle -> tcm_req=1 and ext_req=0 in cycle 0; dmem_resp=RDY_OK and dmem_rdata=32'hDEADBEEF in cycle 1.
- Write to 32'h00010000, ext_req_ack low for 2 cycles then high, ext_resp RDY_OK 3 cycles later -> dmem_req_ack=0,0,1; dmem_resp NOTRDY until the 3rd cycle after ack, then RDY_OK; no tcm_req at any point.
- Back-to-back: TCM read at 32'h00480000, then EXT read at 32'h00020000 presented in the TCM completion cycle -> ext_req asserted in that same cycle; sel_r=EXT afterwards; a spurious tcm_resp=RDY_OK afterwards is not seen on dmem_resp.
- EXT returns RDY_ER for a read of 32'h00030000 -> dmem_resp=RDY_ER for one cycle; fsm returns to IDLE and the next request is accepted.
- rst_n dropped in WAIT with an EXT read outstanding, released, then ext_resp=RDY_OK -> dmem_resp stays NOTRDY and the fsm stays IDLE.
- Build without SCR1_TCM_EN, read 32'h00480000 -> ext_req=1, tcm_req=0.
